// File: rtl/dec_gray2bin_seq.sv
// Sequential Gray-to-binary decoder: resolves one captured Gray word MSB-first, STEP bits per
// cycle, behind valid/ready handshakes, and flags non-single-step Gray sequences.
module dec_gray2bin_seq #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_step_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IdxTop = IW'((WIDTH > 1) ? WIDTH - 2 : 0);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             has_prev_q, has_prev_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] out_bin_q, out_bin_d;
  logic             out_err_q, out_err_d;
  logic [WIDTH-1:0] diff;

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    b_d        = b_q;
    idx_d      = idx_q;
    prev_d     = prev_q;
    has_prev_d = has_prev_q;
    err_d      = err_q;
    out_bin_d  = out_bin_q;
    out_err_d  = out_err_q;
    diff       = in_gray ^ prev_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          g_d            = in_gray;
          b_d            = '0;
          b_d[WIDTH-1]   = in_gray[WIDTH-1];
          // More than one bit set in diff means a multi-bit Gray jump.
          err_d          = has_prev_q && (|(diff & (diff - WIDTH'(1))));
          prev_d         = in_gray;
          has_prev_d     = 1'b1;
          idx_d          = IdxTop;
          if (WIDTH > 1) begin
            state_d = BUSY;
          end else begin
            state_d   = DONE;
            out_bin_d = b_d;
            out_err_d = err_d;
          end
        end
      end
      BUSY: begin
        // Descending loop lets each resolved bit feed the next lower one in the same cycle.
        for (int j = int'(WIDTH) - 2; j >= 0; j--) begin
          if (j <= int'(idx_q) && (j + int'(STEP)) > int'(idx_q)) begin
            b_d[j] = b_d[j+1] ^ g_q[j];
          end
        end
        if (int'(idx_q) < int'(STEP)) begin
          state_d   = DONE;
          out_bin_d = b_d;
          out_err_d = err_q;
        end else begin
          idx_d = idx_q - IW'(STEP);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      g_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      prev_q     <= '0;
      has_prev_q <= 1'b0;
      err_q      <= 1'b0;
      out_bin_q  <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      b_q        <= b_d;
      idx_q      <= idx_d;
      prev_q     <= prev_d;
      has_prev_q <= has_prev_d;
      err_q      <= err_d;
      out_bin_q  <= out_bin_d;
      out_err_q  <= out_err_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_bin      = out_bin_q;
  assign out_step_err = out_err_q;

endmodule

// File: tb/tb_dec_gray2bin_seq.sv
// Directed bench for dec_gray2bin_seq: default build plus a STEP=3 build sharing the reset.
module tb_dec_gray2bin_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_step_err;
  logic [9:0] in_gray, out_bin;

  logic       s3_in_valid, s3_in_ready, s3_out_valid, s3_out_ready, s3_out_step_err;
  logic [9:0] s3_in_gray, s3_out_bin;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dec_gray2bin_seq #(.WIDTH(10), .STEP(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_gray      (in_gray),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bin      (out_bin),
    .out_step_err (out_step_err)
  );

  dec_gray2bin_seq #(.WIDTH(10), .STEP(3)) dut_s3 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (s3_in_valid),
    .in_ready     (s3_in_ready),
    .in_gray      (s3_in_gray),
    .out_valid    (s3_out_valid),
    .out_ready    (s3_out_ready),
    .out_bin      (s3_out_bin),
    .out_step_err (s3_out_step_err)
  );

  // Stimulus only: accept one word, wait for the result, report it, then take it.
  task automatic do_word(input logic [9:0] g, output logic rdy_after, output int lat,
                         output logic [9:0] bin, output logic err);
    in_valid = 1'b1;
    in_gray  = g;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    rdy_after = in_ready;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    bin = out_bin;
    err = out_step_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_bin !== 10'd0) begin bad++; $display("FAIL reset_out_bin got=%b want=0", out_bin); end
    total++; if (out_step_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", out_step_err); end
  endtask

  task automatic test_basic();
    logic r; int lat; logic [9:0] b; logic e;
    do_word(10'b0000000000, r, lat, b, e);
    total++; if (r !== 1'b0) begin bad++; $display("FAIL basic_ready_drop got=%b want=0", r); end
    total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", lat); end
    total++; if (b !== 10'b0000000000) begin bad++; $display("FAIL basic_bin got=%b want=0", b); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", e); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b want=0", out_valid); end
  endtask

  task automatic test_decode();
    logic r; int lat; logic [9:0] b; logic e;
    do_word(10'b1000000000, r, lat, b, e);
    total++; if (b !== 10'b1111111111) begin bad++; $display("FAIL dec1_bin got=%b want=1111111111", b); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL dec1_err got=%b want=0", e); end
    do_word(10'b1110111010, r, lat, b, e);
    total++; if (b !== 10'b1011010011) begin bad++; $display("FAIL dec2_bin got=%b want=1011010011", b); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL dec2_err got=%b want=1", e); end
    total++; if (out_bin !== 10'b1011010011) begin bad++; $display("FAIL dec2_hold got=%b want=1011010011", out_bin); end
    do_word(10'b0110111010, r, lat, b, e);
    total++; if (b !== 10'b0100101100) begin bad++; $display("FAIL dec3_bin got=%b want=0100101100", b); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL dec3_err got=%b want=0", e); end
  endtask

  task automatic test_step_err();
    logic r; int lat; logic [9:0] b; logic e;
    test_reset();
    do_word(10'b0000000000, r, lat, b, e);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL se_first got=%b want=0", e); end
    do_word(10'b0000000001, r, lat, b, e);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL se_dist1 got=%b want=0", e); end
    do_word(10'b0000000001, r, lat, b, e);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL se_dist0 got=%b want=0", e); end
    do_word(10'b0000000110, r, lat, b, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL se_dist2 got=%b want=1", e); end
    total++; if (b !== 10'b0000000100) begin bad++; $display("FAIL se_bin got=%b want=0000000100", b); end
  endtask

  task automatic test_back_to_back();
    int lat;
    in_valid = 1'b1;
    in_gray  = 10'b0000000001;
    @(posedge clk); #1;
    in_gray = 10'b0000000011;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 9) begin bad++; $display("FAIL bp_latency got=%0d want=9", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, out_valid); end
      total++; if (out_bin !== 10'b0000000001) begin bad++; $display("FAIL bp_bin[%0d] got=%b want=0000000001", i, out_bin); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accept got=%b want=0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    total++; if (out_bin !== 10'b0000000010) begin bad++; $display("FAIL bp_next_bin got=%b want=0000000010", out_bin); end
    total++; if (out_step_err !== 1'b0) begin bad++; $display("FAIL bp_next_err got=%b want=0", out_step_err); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic r; int lat; logic [9:0] b; logic e; int seen;
    in_valid = 1'b1;
    in_gray  = 10'b1111111111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mr_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b want=0", out_valid); end
    total++; if (out_bin !== 10'd0) begin bad++; $display("FAIL mr_bin got=%b want=0", out_bin); end
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (out_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL mr_abandoned got=%0d want=0", seen); end
    do_word(10'b0000000101, r, lat, b, e);
    total++; if (b !== 10'b0000000110) begin bad++; $display("FAIL mr_bin_after got=%b want=0000000110", b); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL mr_err_after got=%b want=0", e); end
  endtask

  task automatic test_step3();
    int lat;
    s3_in_valid = 1'b1;
    s3_in_gray  = 10'b1110111010;
    @(posedge clk); #1;
    s3_in_valid = 1'b0;
    lat = 0;
    while (!s3_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 3) begin bad++; $display("FAIL s3_latency got=%0d want=3", lat); end
    total++; if (s3_out_bin !== 10'b1011010011) begin bad++; $display("FAIL s3_bin got=%b want=1011010011", s3_out_bin); end
    s3_out_ready = 1'b1;
    @(posedge clk); #1;
    s3_out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_gray = '0; out_ready = 1'b0;
    s3_in_valid = 1'b0; s3_in_gray = '0; s3_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_decode();
    test_step_err();
    test_back_to_back();
    test_mid_reset();
    test_step3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
